// File: rtl/tm1638_key_reader_if.sv
// Host-side handshake for the TM1638 key reader.
//   READ       : scan request from the host (accepted only while READY=1)
//   KEYS       : last completed scan, byte0 in [7:0] .. byte3 in [31:24]
//   KEYS_VALID : one-cycle pulse when KEYS updates
//   READY      : reader is idle and not owning the pads
interface tm1638_key_reader_if;
  logic        READ;
  logic [31:0] KEYS;
  logic        KEYS_VALID;
  logic        READY;

  modport master (output READ, input KEYS, input KEYS_VALID, input READY);
  modport slave  (input READ, output KEYS, output KEYS_VALID, output READY);
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends command 0x42 on STB/CLK_OUT/DIO, then clocks
// in the four key-scan bytes (LSB first) and presents them as one 32-bit word.
// Ports:
//   CLK_IN  : system clock          RST_IN : async active-high reset
//   host    : READ / KEYS / KEYS_VALID / READY handshake (slave side)
//   STB     : strobe, active low    CLK_OUT: serial clock, idles high
//   DIO     : open-drain data, only ever driven low or released
// Optional: define TM1638_AUTO_POLL_EN to add a free-running poll timer
// (POLL_PERIOD cycles) whose request is ORed with READ.
module tm1638_key_reader #(
  parameter int unsigned HALF_PERIOD  = 4,
  parameter int unsigned TWAIT_CYCLES = 32
`ifdef TM1638_AUTO_POLL_EN
  , parameter int unsigned POLL_PERIOD = 240000
`endif
) (
  input  logic                        CLK_IN,
  input  logic                        RST_IN,
  tm1638_key_reader_if.slave          host,
  output logic                        STB,
  output logic                        CLK_OUT,
  inout  wire                         DIO
);

  localparam int unsigned BIT_PERIOD = 2 * HALF_PERIOD;
  localparam int unsigned CNT_MAX    = (BIT_PERIOD > TWAIT_CYCLES) ? BIT_PERIOD : TWAIT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TWAIT_LAST = CNT_W'(TWAIT_CYCLES - 1);
  localparam logic [7:0]       CMD_BYTE   = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_STB_SETUP, S_CMD, S_TWAIT, S_READ, S_STB_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic             stb_q, stb_d;
  logic             clk_out_q, clk_out_d;
  logic             dio_low_q, dio_low_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [31:0]      keys_q, keys_d;
  logic             keys_valid_q, keys_valid_d;
  logic             ready_q, ready_d;
  logic             dio_meta_q, dio_sync_q;
  logic             scan_req;

  assign DIO             = dio_low_q ? 1'b0 : 1'bz;
  assign STB             = stb_q;
  assign CLK_OUT         = clk_out_q;
  assign host.KEYS       = keys_q;
  assign host.KEYS_VALID = keys_valid_q;
  assign host.READY      = ready_q;

`ifdef TM1638_AUTO_POLL_EN
  localparam int unsigned POLL_W = $clog2(POLL_PERIOD + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

  logic [POLL_W-1:0] poll_cnt_q;
  logic              poll_pend_q;

  // Poll timer; a wrap while busy stays pending until the next idle cycle.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
    end else if (poll_cnt_q == POLL_LAST) begin
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b1;
    end else begin
      poll_cnt_q <= POLL_W'(poll_cnt_q + 1'b1);
      if (state_q == S_IDLE) poll_pend_q <= 1'b0;
    end
  end

  assign scan_req = host.READ | poll_pend_q;
`else
  assign scan_req = host.READ;
`endif

  // Two-flop synchroniser for the returned key data.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      dio_meta_q <= 1'b1;
      dio_sync_q <= 1'b1;
    end else begin
      dio_meta_q <= DIO;
      dio_sync_q <= dio_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stb_q        <= 1'b1;
      clk_out_q    <= 1'b1;
      dio_low_q    <= 1'b0;
      shreg_q      <= '0;
      keys_q       <= '0;
      keys_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stb_q        <= stb_d;
      clk_out_q    <= clk_out_d;
      dio_low_q    <= dio_low_d;
      shreg_q      <= shreg_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state and next-output logic; *_d values are what the pads show next cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = CNT_W'(cnt_q + 1'b1);
    bit_d        = bit_q;
    stb_d        = stb_q;
    clk_out_d    = clk_out_q;
    dio_low_d    = dio_low_q;
    shreg_d      = shreg_q;
    keys_d       = keys_q;
    keys_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (scan_req) begin
          state_d   = S_STB_SETUP;
          stb_d     = 1'b0;
          clk_out_d = 1'b1;
          dio_low_d = 1'b0;
        end
      end
      S_STB_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d   = S_CMD;
          cnt_d     = '0;
          bit_d     = '0;
          clk_out_d = 1'b0;
          dio_low_d = ~CMD_BYTE[0];
        end
      end
      S_CMD: begin
        if (cnt_q == HALF_LAST) clk_out_d = 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd7) begin
            state_d   = S_TWAIT;
            bit_d     = '0;
            dio_low_d = 1'b0;
          end else begin
            bit_d     = 5'(bit_q + 1'b1);
            clk_out_d = 1'b0;
            dio_low_d = ~CMD_BYTE[3'(bit_q[2:0] + 3'd1)];
          end
        end
      end
      S_TWAIT: begin
        if (cnt_q == TWAIT_LAST) begin
          state_d   = S_READ;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end
      end
      S_READ: begin
        if (cnt_q == HALF_LAST) clk_out_d = 1'b1;
        // Sample on the last cycle of the high phase; first bit lands in [0].
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {dio_sync_q, shreg_q[31:1]};
          if (bit_q == 5'd31) begin
            state_d = S_STB_HOLD;
            bit_d   = '0;
          end else begin
            bit_d     = 5'(bit_q + 1'b1);
            clk_out_d = 1'b0;
          end
        end
      end
      S_STB_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          stb_d        = 1'b1;
          keys_d       = shreg_q;
          keys_valid_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_d     = '0;
        stb_d     = 1'b1;
        clk_out_d = 1'b1;
        dio_low_d = 1'b0;
      end
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

endmodule
